// File: rtl/pmu_ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the PMU bus master.
package pmu_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef logic [1:0] mst_state_t;
    localparam mst_state_t ST_IDLE = 2'd0;
    localparam mst_state_t ST_ADDR = 2'd1;
    localparam mst_state_t ST_DATA = 2'd2;
    localparam mst_state_t ST_RESP = 2'd3;

endpackage

// File: rtl/pmu_ahb_master.sv
// Single-outstanding AHB-Lite master: one NONSEQ word transfer per command, one-cycle response pulse.
// Optional stall watchdog enabled by defining PMU_AHB_MST_TIMEOUT_EN.
module pmu_ahb_master
    import pmu_ahb_pkg::*;
#(
    parameter int REG_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [REG_WIDTH-1:0] req_addr_i,
    input  logic [REG_WIDTH-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [REG_WIDTH-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    output logic                 hsel_o,
    output logic [REG_WIDTH-1:0] haddr_o,
    output logic                 hwrite_o,
    output logic [1:0]           htrans_o,
    output logic [2:0]           hsize_o,
    output logic [2:0]           hburst_o,
    output logic [REG_WIDTH-1:0] hwdata_o,
    input  logic                 hready_i,
    input  logic [1:0]           hresp_i,
    input  logic [REG_WIDTH-1:0] hrdata_i
);

    mst_state_t           state_q, state_d;
    logic                 hsel_q, hsel_d;
    logic [1:0]           htrans_q, htrans_d;
    logic [REG_WIDTH-1:0] haddr_q, haddr_d;
    logic                 hwrite_q, hwrite_d;
    logic [REG_WIDTH-1:0] hwdata_q, hwdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [REG_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;

`ifdef PMU_AHB_MST_TIMEOUT_EN
    localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          rsp_to_q, rsp_to_d;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d     = state_q;
        hsel_d      = hsel_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (req_addr_i[1:0] != 2'b00) begin
                        // Misaligned: answer immediately without touching the bus
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = ST_ADDR;
                        hsel_d   = 1'b1;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = req_addr_i;
                        hwrite_d = req_write_i;
                        hwdata_d = req_wdata_i;
                    end
                end
            end
            ST_ADDR: begin
                if (hready_i) begin
                    state_d  = ST_DATA;
                    hsel_d   = 1'b0;
                    htrans_d = HTRANS_IDLE;
                end
            end
            ST_DATA: begin
                if (hready_i) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (hresp_i != HRESP_OKAY);
                    rsp_rdata_d = (!hwrite_q && hresp_i == HRESP_OKAY) ? hrdata_i : '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef PMU_AHB_MST_TIMEOUT_EN
        rsp_to_d = 1'b0;
        cnt_d    = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_ADDR || state_q == ST_DATA) begin
            if (cnt_q == CNT_MAX) begin
                state_d     = ST_RESP;
                hsel_d      = 1'b0;
                htrans_d    = HTRANS_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_to_d    = 1'b1;
                rsp_rdata_d = '0;
            end else if (!hready_i) begin
                cnt_d = cnt_q + 1'b1;
                // Last tolerated stall: withdraw the transfer one cycle before the abort response
                if (cnt_q == CNT_LAST) begin
                    hsel_d   = 1'b0;
                    htrans_d = HTRANS_IDLE;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            hsel_q      <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef PMU_AHB_MST_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hsel_q      <= hsel_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef PMU_AHB_MST_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_to_q    <= rsp_to_d;
`endif
        end
    end

    // Gated by reset so no command can be taken while the FSM is being cleared
    assign req_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
`ifdef PMU_AHB_MST_TIMEOUT_EN
    assign rsp_timeout_o = rsp_to_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif
    assign hsel_o   = hsel_q;
    assign haddr_o  = haddr_q;
    assign hwrite_o = hwrite_q;
    assign htrans_o = htrans_q;
    assign hsize_o  = HSIZE_WORD;
    assign hburst_o = HBURST_SINGLE;
    assign hwdata_o = hwdata_q;

endmodule

// File: doc/pmu_ahb_master.md
# pmu_ahb_master

Single-outstanding AHB-Lite master that converts a simple valid/ready command port into word-sized AHB transfers toward the PMU register bank (`pmu_ahb` slave). It sits between a debug or host agent and the PMU, and is also the reusable bus driver for the PMU benches. It issues one NONSEQ transfer per command and returns read data or error status on a single-cycle response pulse. A watchdog can abort transfers on which the slave stalls.

## Interface
Parameters:
- `REG_WIDTH`, 32, address and data width.
- `TIMEOUT_CYCLES`, 1024, maximum number of `hready_i`-low cycles tolerated per transfer (watchdog builds only).

Ports:
- `clk_i`  in  1  clock; everything is on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  command valid.
- `req_ready_o`  out  1  command accepted when high together with `req_valid_i`.
- `req_write_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  REG_WIDTH  byte address.
- `req_wdata_i`  in  REG_WIDTH  write data.
- `rsp_valid_o`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata_o`  out  REG_WIDTH  read data; 0 for writes and errors.
- `rsp_err_o`  out  1  error response, misaligned address, or timeout.
- `rsp_timeout_o`  out  1  the error was a watchdog abort.
- `hsel_o`  out  1  slave select; high during the address phase.
- `haddr_o`  out  REG_WIDTH  address.
- `hwrite_o`  out  1  write flag.
- `htrans_o`  out  2  transfer type; 2'b00 IDLE, 2'b10 NONSEQ only.
- `hsize_o`  out  3  constant 3'b010 (word).
- `hburst_o`  out  3  constant 3'b000 (SINGLE).
- `hwdata_o`  out  REG_WIDTH  write data for the data phase.
- `hready_i`  in  1  slave ready.
- `hresp_i`  in  2  2'b00 OKAY, 2'b01 ERROR; other codes are treated as ERROR.
- `hrdata_i`  in  REG_WIDTH  read data.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE
  - `req_ready_o`=1.
  - On handshake with `req_addr_i[1:0]`≠0: no bus activity; go to RESP with err=1, timeout=0.
  - On handshake with an aligned address: register addr, write flag and wdata; go to ADDR.
- ADDR
  - Drives `hsel_o`=1, `htrans_o`=NONSEQ, and the registered `haddr_o`/`hwrite_o`.
  - The address phase ends on the first edge with `hready_i`=1; go to DATA.
- DATA
  - Drives `htrans_o`=IDLE and `hsel_o`=0.
  - `hwdata_o` holds the write data for the whole phase.
  - On the first edge with `hready_i`=1: capture `hrdata_i` (reads with OKAY only), set err=(`hresp_i`≠OKAY), go to RESP.
  - ERROR-with-`hready_i`-low cycles are waited through; completion is taken on the `hready_i`-high cycle.
- RESP
  - `rsp_valid_o`=1 for exactly one cycle, then IDLE.
  - `req_ready_o`=0 in every state except IDLE. Maximum throughput is one command every 4 cycles.
- `haddr_o`, `hwrite_o` and `hwdata_o` hold their last values while IDLE. `hwdata_o` is never changed mid-transfer.
- `rsp_rdata_o`, `rsp_err_o` and `rsp_timeout_o` are valid only with `rsp_valid_o`. They are zeroed in all other cycles.

## Timing
- Reset values of all outputs are 0, except `hsize_o`=3'b010. FSM resets to IDLE.
- `rst_i` asserted in any state:
  - on the next edge the FSM is IDLE and `htrans_o`=IDLE;
  - no response is produced for the interrupted command.
- Command handshake at edge N: the address phase is visible from cycle N+1.
- With zero wait states: DATA in cycle N+2, `rsp_valid_o` in cycle N+3.
- Each wait cycle (`hready_i`=0) in ADDR or DATA adds one cycle of latency.
- Misaligned command accepted at edge N: `rsp_valid_o` in cycle N+1, no bus cycles.
- All AHB outputs are driven from registers; there are no combinational input-to-output paths except `req_ready_o` (decoded from state).

## Configuration
- `PMU_AHB_MST_TIMEOUT_EN` defined:
  - a `$clog2(TIMEOUT_CYCLES+1)`-bit counter clears on entry to ADDR and counts `hready_i`-low cycles in ADDR and DATA;
  - when it reaches `TIMEOUT_CYCLES`, the FSM drives `htrans_o`=IDLE and goes to RESP with err=1, timeout=1.
- Undefined: no counter; the master waits indefinitely; `rsp_timeout_o` is tied to 0.

## Structure
- Shared package `pmu_ahb_pkg` holds:
  - `htrans` encodings (IDLE, NONSEQ);
  - `hresp` encodings (OKAY, ERROR);
  - the `HSIZE_WORD` constant;
  - the FSM state typedef.
- Single module; no sub-module. The watchdog is an inline counter under the macro.

## Test plan
- Reset, then write 0x00000002 to 0x80100000 with a zero-wait slave:
  - `htrans_o`=2'b10 for exactly one cycle;
  - `hwdata_o`=0x2 in the following cycle;
  - `rsp_valid_o` 3 cycles after handshake with err=0.
- Read 0x801000AC with the slave returning 0xCAFECAFE after 3 wait states in DATA: `rsp_rdata_o`=0xCAFECAFE, latency 6 cycles, `hwdata_o` stable throughout.
- Slave returns two-cycle ERROR (`hready_i` low, then high) on a read: `rsp_err_o`=1, `rsp_rdata_o`=0, `rsp_timeout_o`=0.
- Command at address 0x80100002: no NONSEQ cycle on the bus; `rsp_valid_o` next cycle with err=1.
- With `PMU_AHB_MST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, hold `hready_i`=0 forever: after 8 stall cycles `htrans_o`=IDLE, then `rsp_err_o`=1 and `rsp_timeout_o`=1; the next command is accepted normally.
- Assert `rst_i` during the DATA phase of a write: next cycle all outputs are at reset values and no `rsp_valid_o` pulse occurs; 10000 random commands then complete one response per command.
